// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver for 8N1-style frames. Feeds the receive FIFO
// directly: dout -> w_data, rx_done_tick -> wr.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326,
    parameter int DVSR_W  = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [DVSR_W-1:0] TICK_LAST = DVSR_W'(DVSR - 1);
    localparam logic [N_W-1:0]    N_LAST    = N_W'(DBIT - 1);
    localparam logic [3:0]        MID_START = 4'd7;
    localparam logic [3:0]        BIT_LAST  = 4'd15;
    localparam logic [3:0]        STOP_LAST = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state, state_next;
    logic              rx_meta, rx_s, rx_p;
    logic              fall;
    logic [DVSR_W-1:0] tick_cnt;
    logic              tick;
    logic [3:0]        s, s_next;
    logic [N_W-1:0]    n, n_next;
    logic [DBIT-1:0]   b, b_next;
    logic              done_next, ferr_next;

    // Synchronizer plus one extra delay stage for falling-edge detection.
    // Reset to 1 so an idle-high line never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_p    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_p    <= rx_s;
        end
    end

    assign fall = rx_p & ~rx_s;

    // Free-running oversample divider; deliberately not resynchronised to
    // the start edge, so sample phase jitters by up to one tick period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            rx_done_tick <= done_next;
            frame_err    <= ferr_next;
            if (done_next) begin
                dout <= b;
            end
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                // Edge, not level: a held-low break yields only one attempt.
                if (fall) begin
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    s_next = s + 4'd1;
                    if (s == MID_START) begin
                        if (!rx_s) begin
                            s_next     = '0;
                            n_next     = '0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    s_next = s + 4'd1;
                    if (s == BIT_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    s_next = s + 4'd1;
                    if (s == STOP_LAST) begin
                        state_next = IDLE;
                        if (rx_s) begin
                            done_next = 1'b1;
                        end else begin
                            ferr_next = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
